// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the CPU/debug memory arbiter.
package mem_arb_pkg;

    // Which requester owns the memory port in the current cycle.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_DBG  = 2'd2
    } requester_t;

    // Data memory depth in 32-bit words.
    localparam int MEM_WORDS   = 32;
    // Highest byte-address bit that selects a word inside the memory.
    localparam int MEM_ADDR_HI = 6;

    // A byte address hits the memory only when every bit above the word
    // index is zero; the two low bits are ignored (word access only).
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr[31:MEM_ADDR_HI+1] == '0);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups both requester ports and the memory port.
// The slave modport is the arbiter; the master modport is the
// requesters plus the memory model on the other side.
interface mem_arbiter_if;

    // CPU load/store port
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_rerr;

    // Debug/loader port
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_rerr;

    // Shared memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_rerr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_rerr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_starve_counter.sv
// mem_arb_starve_counter: counts consecutive denied debug cycles and
// flags when the debug port must be force-granted. Saturates at the limit.
module mem_arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins over increment, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (CPU, debug) for the 32-word data
// memory. Zero-latency grant, registered response one cycle later.
// Build option MEM_ARB_ROUND_ROBIN_EN: replaces CPU priority plus the
// starvation counter with alternating winners on conflict cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    requester_t  winner;
    logic        conflict;
    logic        dbg_wins_conflict;
    logic        cpu_gnt;
    logic        dbg_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;

    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic [31:0] cpu_rdata_q,  cpu_rdata_d;
    logic        cpu_rerr_q,   cpu_rerr_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0] dbg_rdata_q,  dbg_rdata_d;
    logic        dbg_rerr_q,   dbg_rerr_d;

    assign conflict = bus.cpu_req & bus.dbg_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = debug won the most recent conflict, so the CPU wins the next.
    // Reset value of 1 hands the first conflict to the CPU.
    logic last_winner_q;
    logic last_winner_d;

    // Only conflict cycles move the round-robin pointer.
    always_comb begin
        last_winner_d = last_winner_q;
        if (conflict && !reset) begin
            last_winner_d = dbg_gnt;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q <= 1'b1;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

    assign dbg_wins_conflict = ~last_winner_q;
`else
    logic at_limit;

    // Debug starves only while it asks and loses; any debug grant or
    // withdrawn request restarts the count.
    mem_arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (bus.dbg_req & ~dbg_gnt),
        .clr_i      (dbg_gnt | ~bus.dbg_req),
        .at_limit_o (at_limit)
    );

    assign dbg_wins_conflict = at_limit;
`endif

    // Pick the winner; nobody is granted while reset is held.
    always_comb begin
        winner = REQ_NONE;
        if (!reset) begin
            if (conflict) begin
                winner = dbg_wins_conflict ? REQ_DBG : REQ_CPU;
            end else if (bus.cpu_req) begin
                winner = REQ_CPU;
            end else if (bus.dbg_req) begin
                winner = REQ_DBG;
            end
        end
    end

    assign cpu_gnt       = (winner == REQ_CPU);
    assign dbg_gnt       = (winner == REQ_DBG);
    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt & ~reset;

    // Memory port follows the debug side only when debug wins; otherwise
    // it idles on the CPU side so the CPU path stays short.
    always_comb begin
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        sel_we    = bus.cpu_we;
        if (dbg_gnt) begin
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
            sel_we    = bus.dbg_we;
        end
    end

    assign in_range      = addr_in_range(sel_addr);
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_we    = (cpu_gnt | dbg_gnt) & sel_we & in_range;

    // Response captured at the granting edge; writes and out-of-range
    // accesses return zero data.
    always_comb begin
        cpu_rvalid_d = cpu_gnt;
        cpu_rerr_d   = cpu_gnt & ~in_range;
        cpu_rdata_d  = (cpu_gnt & ~sel_we & in_range) ? bus.mem_rdata : 32'd0;
        dbg_rvalid_d = dbg_gnt;
        dbg_rerr_d   = dbg_gnt & ~in_range;
        dbg_rdata_d  = (dbg_gnt & ~sel_we & in_range) ? bus.mem_rdata : 32'd0;
    end

    // Response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            cpu_rerr_q   <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= 32'd0;
            dbg_rerr_q   <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rerr_q   <= cpu_rerr_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rerr_q   <= dbg_rerr_d;
        end
    end

    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rerr   = cpu_rerr_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_rerr   = dbg_rerr_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port 32-word data memory between the CPU load/store path and a debug/loader port. The CPU has fixed priority, and an anti-starvation counter guarantees the debug port forward progress. The arbiter sits between both requesters and `memory`, driving its address, write-data and write-enable. It returns registered read data and a one-cycle-later response to the winner.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied debug-request cycles before the debug port is force-granted; legal range 1–15.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cpu_req` / `dbg_req`  in  1  access request, level, held until granted
- `cpu_we` / `dbg_we`  in  1  1 = write, 0 = read
- `cpu_addr` / `dbg_addr`  in  32  byte address
- `cpu_wdata` / `dbg_wdata`  in  32  write data
- `cpu_gnt` / `dbg_gnt`  out  1  request accepted this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid` / `dbg_rvalid`  out  1  response for the access granted last cycle
- `cpu_rdata` / `dbg_rdata`  out  32  read data, 0 for writes and errors
- `cpu_rerr` / `dbg_rerr`  out  1  last granted access was out of range
- `mem_addr`  out  32  byte address to memory
- `mem_wdata`  out  32  write data to memory
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  32  memory combinational read data

## Operation
- At most one grant per cycle; `cpu_gnt & dbg_gnt` is never 1.
- Priority:
  - Only one requester active: it is granted.
  - Both active: CPU wins, unless `starve_cnt == STARVE_LIMIT`, in which case debug wins.
- `starve_cnt` (4 bits) updates each cycle:
  - increments when `dbg_req & ~dbg_gnt`;
  - clears on `dbg_gnt` or when `dbg_req` is 0;
  - saturates at `STARVE_LIMIT`.
- Mux: `mem_addr` and `mem_wdata` follow the winner. With no grant they follow the CPU port and `mem_we` is 0.
- Range check: an access is in range iff `addr[31:7] == 0`. `addr[1:0]` is ignored (word access).
- `mem_we = granted & we & in_range`. An out-of-range write never reaches memory.
- Response register, loaded at the granting edge:
  - `rvalid` is set for the winner only;
  - `rdata = mem_rdata` for an in-range read, else 0;
  - `rerr = ~in_range`.
- Writes also produce `rvalid` (write acknowledge) with `rdata` 0.

## Timing
- Grant: same cycle as request (zero latency), combinational from the `req`, `addr` and `starve_cnt` registers.
- Response: exactly 1 cycle after grant, for one cycle. Back-to-back grants give back-to-back `rvalid`.
- Read-after-write to the same word in consecutive cycles returns the new data (memory writes on the grant edge).
- Reset values:
  - `cpu_gnt`, `dbg_gnt`, `cpu_stall`, `mem_we` are forced 0 while `reset` is high;
  - `rvalid` 0, `rdata` 0, `rerr` 0 and `starve_cnt` 0 on the cycle after reset.
- Reset mid-contention: pending requests are dropped, with no response for the cycle in which reset is high. Arbitration restarts with CPU priority.
- Debug request withdrawn before grant: the counter clears; no penalty to the CPU.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
- Defined: `starve_cnt` and `STARVE_LIMIT` are unused. A 1-bit `last_winner` register decides conflicts: the requester that did not win the last conflict wins the next one. Reset value favours the CPU. Non-conflict cycles do not update `last_winner`.
- Undefined: fixed CPU priority with the starvation counter, as above.

## Structure
- Package `mem_arb_pkg`:
  - `requester_t` enum (`REQ_NONE`, `REQ_CPU`, `REQ_DBG`);
  - `MEM_WORDS = 32`;
  - `MEM_ADDR_HI = 6`.
- Sub-module `mem_arb_starve_counter`: saturating counter with `inc`/`clr` inputs and an `at_limit` output, parameterised by `STARVE_LIMIT`. It is not instantiated when `MEM_ARB_ROUND_ROBIN_EN` is defined.
- The top level holds the grant logic, address mux, range check and response registers.

## Test plan
- CPU-only read at `0x08`, with `mem[2] = 0xDEADBEEF` → `cpu_gnt` 1 in the same cycle; next cycle `cpu_rvalid` 1, `cpu_rdata` `0xDEADBEEF`, `cpu_rerr` 0.
- Both requesting continuously, `STARVE_LIMIT = 4` → `cpu_gnt` in cycles 0–3, `dbg_gnt` in cycle 4, CPU again in cycle 5; `cpu_stall` 1 only in cycle 4.
- Debug write at `0x7C`, data `0x12345678`, then debug read at `0x7C` → `mem_we` 1 with `mem_addr` `0x7C`; read `dbg_rdata` `0x12345678`.
- CPU write at `0x80` → `mem_we` 0; next cycle `cpu_rvalid` 1, `cpu_rerr` 1, `cpu_rdata` 0; memory unchanged.
- Reset in cycle 2 of contention → both grants 0 in that cycle; cycle 3 has `rvalid` 0 and the counter at 0.
- With `MEM_ARB_ROUND_ROBIN_EN`, both requesting for 4 cycles → grants alternate CPU, DBG, CPU, DBG.
